// File: rtl/icache_refill_controller.sv
// Direct-mapped I-cache sequencer: tag lookup, block refill from memory, line write, response, whole-cache flush.
// Latency: hit -> resp_valid two cycles after request acceptance; miss adds request wait + block_size beats + write + re-lookup.
// Backpressure: req_ready low outside IDLE and during flush; resp/mem request outputs held stable until their ready.
//
// Ports:
//   clock, reset (synchronous, active-high)
//   req_*      : core fetch request handshake and byte address
//   resp_*     : core response handshake and instruction
//   flush      : single-cycle invalidate-all request, deferred while a fetch is in flight
//   lookup_address, tag, tag_valid, instruction : combinational storage read port
//   write_in, write_line_index, write_block, write_tag, invalidate_all : storage write port
//   mem_req_*  : block read request to memory; mem_resp_* : returned beats, word 0 first, no backpressure
module icache_refill_controller #(
    parameter int  offset_width = 2,
    parameter int  line_width   = 6,
    localparam int tag_width    = 32 - offset_width - line_width - 2,
    localparam int block_size   = 1 << offset_width
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_addr,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [31:0]                  resp_instruction,
    input  logic                         flush,
    output logic [31:0]                  lookup_address,
    input  logic [tag_width-1:0]         tag,
    input  logic                         tag_valid,
    input  logic [31:0]                  instruction,
    output logic                         write_in,
    output logic [line_width-1:0]        write_line_index,
    output logic [32*block_size-1:0]     write_block,
    output logic [tag_width-1:0]         write_tag,
    output logic                         invalidate_all,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [31:0]                  mem_req_addr,
    input  logic                         mem_resp_valid,
    input  logic [31:0]                  mem_resp_data
);

    localparam int line_lo = offset_width + 2;
    localparam int tag_lo  = line_width + offset_width + 2;
    localparam logic [offset_width-1:0] last_beat = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        WRITE,
        RESPOND
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [31:0]             addr_q;
    logic [offset_width-1:0] beat_q;
    logic [31:0]             buf_q [block_size];
    logic [31:0]             resp_q;
    logic                    flush_pending_q;

    logic [tag_width-1:0]    addr_tag;
    logic [line_width-1:0]   addr_line;
    logic                    lookup_hit;
    logic                    refill_beat;

    assign addr_tag    = addr_q[31:tag_lo];
    assign addr_line   = addr_q[tag_lo-1:line_lo];
    assign lookup_hit  = tag_valid && (tag == addr_tag);
    assign refill_beat = (state_q == REFILL) && mem_resp_valid;

    // The storage is always addressed by the latched request; after a refill
    // the same address is looked up again and is guaranteed to hit.
    assign lookup_address   = addr_q;
    assign resp_instruction = resp_q;
    assign mem_req_addr     = {addr_q[31:line_lo], {line_lo{1'b0}}};
    assign write_line_index = addr_line;
    assign write_tag        = addr_tag;

    always_comb begin
        write_block = '0;
        for (int j = 0; j < block_size; j++) begin
            write_block[32*j +: 32] = buf_q[j];
        end
    end

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        write_in       = 1'b0;
        invalidate_all = 1'b0;
        mem_req_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending or fresh flush wins over a waiting request so
                // the request is served from the invalidated cache.
                if (flush_pending_q || flush) begin
                    invalidate_all = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                state_d = lookup_hit ? RESPOND : MISS_REQ;
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_resp_valid && (beat_q == last_beat)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                write_in = 1'b1;
                state_d  = LOOKUP;
            end
            RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            beat_q          <= '0;
            resp_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_ready && req_valid) begin
                addr_q <= req_addr;
            end
            if ((state_q == LOOKUP) && lookup_hit) begin
                resp_q <= instruction;
            end
            if ((state_q == MISS_REQ) && mem_req_ready) begin
                beat_q <= '0;
            end else if (refill_beat) begin
                beat_q <= beat_q + 1'b1;
            end
            // Flushes seen outside IDLE are remembered; WRITE can never
            // coincide with invalidate_all because the flush waits for IDLE.
            if (invalidate_all) begin
                flush_pending_q <= 1'b0;
            end else if (flush && (state_q != IDLE)) begin
                flush_pending_q <= 1'b1;
            end
        end
    end

    // Refill buffer needs no reset: it is fully rewritten before every WRITE.
    always_ff @(posedge clock) begin
        if (refill_beat) begin
            buf_q[beat_q] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_icache_refill_controller.sv
module tb_icache_refill_controller;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_instruction;
    logic          flush;
    logic [31:0]   lookup_address;
    logic [21:0]   tag;
    logic          tag_valid;
    logic [31:0]   instruction;
    logic          write_in;
    logic [5:0]    write_line_index;
    logic [127:0]  write_block;
    logic [21:0]   write_tag;
    logic          invalidate_all;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic          mem_resp_valid = 1'b0;
    logic [31:0]   mem_resp_data  = '0;

    always #5 clock = ~clock;

    icache_refill_controller dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_instruction (resp_instruction),
        .flush            (flush),
        .lookup_address   (lookup_address),
        .tag              (tag),
        .tag_valid        (tag_valid),
        .instruction      (instruction),
        .write_in         (write_in),
        .write_line_index (write_line_index),
        .write_block      (write_block),
        .write_tag        (write_tag),
        .invalidate_all   (invalidate_all),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int beats_sent  = 0;
    int beat_gap    = 0;
    int inv_cnt     = 0;
    int inv_cyc     = 0;
    int resp_cyc    = 0;

    typedef struct packed {
        logic [5:0]   line;
        logic [21:0]  tg;
        logic [127:0] blk;
    } wr_t;

    logic [31:0] exp_resp_q [$];
    logic [31:0] exp_mreq_q [$];
    wr_t         exp_wr_q   [$];

    // Reference view of which line holds which tag, maintained from stimulus only.
    logic        ref_valid [64];
    logic [21:0] ref_tag   [64];

    // Storage array environment, written by the DUT's write port.
    logic        st_valid [64] = '{default: 1'b0};
    logic [21:0] st_tag   [64] = '{default: '0};
    logic [31:0] st_data  [64][4];

    assign tag         = st_tag[lookup_address[9:4]];
    assign tag_valid   = st_valid[lookup_address[9:4]];
    assign instruction = st_data[lookup_address[9:4]][lookup_address[3:2]];

    always @(posedge clock) begin
        if (write_in) begin
            st_valid[write_line_index] <= 1'b1;
            st_tag[write_line_index]   <= write_tag;
            for (int j = 0; j < 4; j++) begin
                st_data[write_line_index][j] <= write_block[32*j +: 32];
            end
        end
        if (invalidate_all) begin
            for (int i = 0; i < 64; i++) begin
                st_valid[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Block 0x1000 returns A0..A3; every other block gets distinct data.
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] blk;
        blk = {a[31:4], 4'b0000} ^ 32'h0000_1000;
        return 32'h0000_00A0 + {30'b0, a[3:2]} + (blk << 8);
    endfunction

    initial begin : cycle_count
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // Memory: checks each accepted block request, then streams its four beats.
    initial begin : mem_model
        logic [31:0] b;
        forever begin
            @(negedge clock);
            if (!reset && mem_req_valid && mem_req_ready) begin
                b = mem_req_addr;
                if (exp_mreq_q.size() == 0) chk("mem_req_unexpected", 1, 0);
                else chk("mem_req_addr", b, exp_mreq_q.pop_front());
                @(posedge clock); #1;
                for (int i = 0; i < 4; i++) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memword(b + 32'(4 * i));
                    beats_sent     = i + 1;
                    @(posedge clock); #1;
                    if (beat_gap != 0 && i == 1) begin
                        mem_resp_valid = 1'b0;
                        @(posedge clock); #1;
                    end
                end
                mem_resp_valid = 1'b0;
                beats_sent     = 0;
            end
        end
    end

    // Output monitor: scoreboards responses and line writes, checks stability under backpressure.
    initial begin : monitor
        logic        pv = 1'b0, pr = 1'b0, mv = 1'b0, mr = 1'b0;
        logic [31:0] pd = '0, ma = '0;
        wr_t         w;
        forever begin
            @(negedge clock);
            if (reset) begin
                pv = 1'b0;
                mv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("resp_valid_held", resp_valid, 1);
                    chk("resp_instr_stable", resp_instruction, pd);
                end
                if (mv && !mr) begin
                    chk("mem_req_valid_held", mem_req_valid, 1);
                    chk("mem_req_addr_stable", mem_req_addr, ma);
                end
                if (resp_valid && resp_ready) begin
                    resp_cyc = cyc;
                    if (exp_resp_q.size() == 0) chk("resp_unexpected", 1, 0);
                    else chk("resp_instruction", resp_instruction, exp_resp_q.pop_front());
                end
                if (write_in) begin
                    if (exp_wr_q.size() == 0) chk("write_unexpected", 1, 0);
                    else begin
                        w = exp_wr_q.pop_front();
                        chk("write_line", write_line_index, w.line);
                        chk("write_tag", write_tag, w.tg);
                        chk("write_block", write_block, w.blk);
                    end
                    if (invalidate_all) chk("write_inv_overlap", 1, 0);
                end
                if (invalidate_all) begin
                    inv_cnt++;
                    inv_cyc = cyc;
                    chk("req_ready_during_inv", req_ready, 0);
                end
                pv = resp_valid; pr = resp_ready; pd = resp_instruction;
                mv = mem_req_valid; mr = mem_req_ready; ma = mem_req_addr;
            end
        end
    end

    // Pushes expectations from the reference view and performs the request handshake.
    // With abort set the transaction is expected to be killed by reset during refill.
    task automatic issue(input logic [31:0] a, input bit abort);
        logic [5:0]  ln;
        logic [21:0] tg;
        logic [31:0] b;
        wr_t         w;
        int          n;
        ln = a[9:4];
        tg = a[31:10];
        b  = {a[31:4], 4'b0000};
        if (!(ref_valid[ln] && ref_tag[ln] == tg)) begin
            exp_mreq_q.push_back(b);
            if (!abort) begin
                w.line = ln;
                w.tg   = tg;
                w.blk  = {memword(b + 32'd12), memword(b + 32'd8), memword(b + 32'd4), memword(b)};
                exp_wr_q.push_back(w);
                ref_valid[ln] = 1'b1;
                ref_tag[ln]   = tg;
            end
        end
        if (!abort) exp_resp_q.push_back(memword(a));
        req_addr  = a;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) chk("req_accept_timeout", 0, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        int n;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 400);
        if (!resp_valid) chk("resp_timeout", 0, 1);
        n = 0;
        while (exp_resp_q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (exp_resp_q.size() != 0) chk("resp_drain_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    endtask

    initial begin : main
        int lat, n, inv_before;
        for (int i = 0; i < 64; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        resp_ready    = 1'b1;
        mem_req_ready = 1'b1;
        flush         = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_write_in", write_in, 0);
        chk("rst_invalidate_all", invalidate_all, 0);
        chk("rst_resp_instruction", resp_instruction, 0);
        chk("rst_lookup_address", lookup_address, 0);
        @(posedge clock); #1;

        // Cold miss with refill, then a hit in the same block.
        issue(32'h0000_1004, 0);
        wait_resp(lat);
        chk("miss_latency_min", lat >= 8, 1);
        issue(32'h0000_100C, 0);
        wait_resp(lat);
        chk("hit_latency", lat, 2);

        // Conflict on line 0 evicts tag 0x4; the old address must miss again.
        issue(32'h0000_2004, 0);
        wait_resp(lat);
        chk("conflict_miss_latency", lat >= 8, 1);
        issue(32'h0000_1004, 0);
        wait_resp(lat);
        chk("conflict_remiss_latency", lat >= 8, 1);

        // Flush in IDLE with a request waiting: flush goes first, request then misses.
        clear_ref();
        inv_before = inv_cnt;
        flush = 1'b1;
        fork
            begin
                @(posedge clock); #1;
                flush = 1'b0;
            end
        join_none
        issue(32'h0000_1008, 0);
        wait_resp(lat);
        chk("flush_idle_inv_count", inv_cnt - inv_before, 1);
        chk("flush_idle_remiss", lat >= 8, 1);

        // Flush during refill: response still returned, then a single invalidate in IDLE.
        issue(32'h0000_4010, 0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (beats_sent < 1 && n < 100);
        if (beats_sent < 1) chk("refill_start_timeout", 0, 1);
        inv_before = inv_cnt;
        @(posedge clock); #1 flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        clear_ref();
        wait_resp(lat);
        repeat (3) @(posedge clock);
        #1;
        chk("flush_refill_inv_count", inv_cnt - inv_before, 1);
        chk("flush_after_resp_cycle", inv_cyc, resp_cyc + 1);
        issue(32'h0000_4010, 0);
        wait_resp(lat);
        chk("flush_refill_remiss", lat >= 8, 1);

        // Reset after two of four beats: nothing written, nothing returned.
        issue(32'h0000_5000, 1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (beats_sent != 2 && n < 100);
        if (beats_sent != 2) chk("abort_beats_timeout", 0, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_resp_instruction", resp_instruction, 0);
        chk("abort_mem_req_valid", mem_req_valid, 0);
        repeat (6) @(posedge clock);
        #1;
        issue(32'h0000_5000, 0);
        wait_resp(lat);
        chk("abort_then_miss", lat >= 8, 1);

        // Backpressure: memory request held 3 cycles, response held 5 cycles.
        mem_req_ready = 1'b0;
        resp_ready    = 1'b0;
        issue(32'h0000_3008, 0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_req_valid && n < 100);
        if (!mem_req_valid) chk("bp_mem_req_timeout", 0, 1);
        repeat (3) @(posedge clock);
        #1 mem_req_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!resp_valid && n < 100);
        if (!resp_valid) chk("bp_resp_timeout", 0, 1);
        repeat (5) @(posedge clock);
        #1 resp_ready = 1'b1;
        wait_resp(lat);

        // Refill with a gap between beats, then a hit at another offset.
        beat_gap = 1;
        issue(32'h0000_6004, 0);
        wait_resp(lat);
        chk("gap_miss_latency", lat >= 9, 1);
        beat_gap = 0;
        issue(32'h0000_6000, 0);
        wait_resp(lat);
        chk("gap_hit_latency", lat, 2);

        repeat (4) @(posedge clock);
        #1;
        chk("resp_queue_empty", exp_resp_q.size(), 0);
        chk("mem_req_queue_empty", exp_mreq_q.size(), 0);
        chk("write_queue_empty", exp_wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
